tether_rx: RTL

Receive-side counterpart of `tether`. It accepts RMII receive dibits from the PHY, finds preamble and SFD, filters on destination MAC, and strips the 14-byte Ethernet header. Payload dibits are forwarded on an AXI-style valid/data stream with the 4-byte FCS removed, and a CRC-32 verdict is reported at end of frame. It sits between the PHY RX pins and the application consumer of `tether` payloads.

---
 rtl/tether_pkg.sv | 38 +++
 rtl/crc32_dibit.sv | 31 +++
 rtl/tether_rx.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tether_pkg.sv
// rtl/tether_pkg.sv - shared types and constants for the tether Ethernet TX/RX pair
package tether_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_DST,
    S_SRC,
    S_TYPE,
    S_PAYLOAD,
    S_DROP
  } state_t;

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  localparam logic [7:0]  DST_DIBITS   = 8'd24;
  localparam logic [7:0]  SRC_DIBITS   = 8'd24;
  localparam logic [7:0]  TYPE_DIBITS  = 8'd8;
  localparam logic [4:0]  FCS_DIBITS   = 5'd16;
  localparam logic [7:0]  PREAMBLE_MIN = 8'd15;

  // Smallest legal frame body: the FCS plus one payload byte.
  localparam logic [15:0] MIN_PAYLOAD_DIBITS = 16'd20;

  // Reflected CRC-32 advanced by one dibit; d[0] is the earlier wire bit.
  function automatic logic [31:0] crc_step2(input logic [31:0] crc, input logic [1:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 2; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ CRC_POLY;
      else             c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_dibit.sv
// rtl/crc32_dibit.sv - registered reflected CRC-32 engine, two bits per clock
module crc32_dibit
  import tether_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        en,
  input  logic [1:0]  d,
  output logic [31:0] crc
);

  logic [31:0] crc_q;
  logic [31:0] crc_d;

  // Next CRC value: clear has priority over a data update.
  always_comb begin
    crc_d = crc_q;
    if (clear)   crc_d = CRC_INIT;
    else if (en) crc_d = crc_step2(crc_q, d);
  end

  // CRC register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) crc_q <= CRC_INIT;
    else      crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/tether_rx.sv
// rtl/tether_rx.sv - RMII receive: preamble/SFD, MAC filter, header strip, FCS strip and check
module tether_rx
  import tether_pkg::*;
#(
  parameter logic [47:0] MY_MAC    = 48'h69_69_5A_06_54_91,
  parameter logic [15:0] ETHERTYPE = 16'h0800
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       crsdv,
  input  logic [1:0] rxd,
  output logic       axiov,
  output logic [1:0] axiod,
  output logic       frame_done,
  output logic       crc_ok,
  output logic       frame_err
);

  // Reorder header fields into wire order so dibit k sits at bits [2k+1:2k].
  function automatic logic [47:0] wire_order48(input logic [47:0] v);
    logic [47:0] r;
    for (int b = 0; b < 6; b++) r[8*b +: 8] = v[8*(5-b) +: 8];
    return r;
  endfunction

  localparam logic [47:0] MAC_WIRE  = wire_order48(MY_MAC);
  localparam logic [15:0] TYPE_WIRE = {ETHERTYPE[7:0], ETHERTYPE[15:8]};

  // Input stage.
  logic       crsdv_q, crsdv_d;
  logic [1:0] rxd_q, rxd_d;
  logic       in_vld_q, in_vld_d;

  // Frame FSM and header bookkeeping.
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        armed_q, armed_d;
  logic        uc_ok_q, uc_ok_d;
  logic        bc_ok_q, bc_ok_d;
  logic        type_ok_q, type_ok_d;

  // FCS-holdback delay line.
  logic [31:0] line_q, line_d;
  logic [4:0]  occ_q, occ_d;
  logic [15:0] pay_cnt_q, pay_cnt_d;

  // Registered outputs.
  logic        axiov_q, axiov_d;
  logic [1:0]  axiod_q, axiod_d;
  logic        frame_done_q, frame_done_d;
  logic        crc_ok_q, crc_ok_d;
  logic        frame_err_q, frame_err_d;

  logic        crc_clear;
  logic        crc_en;
  logic [31:0] crc;
  logic [1:0]  mac_exp;
  logic [1:0]  type_exp;

  crc32_dibit u_crc (
    .clk   (clk),
    .rst   (rst),
    .clear (crc_clear),
    .en    (crc_en),
    .d     (rxd_q),
    .crc   (crc)
  );

  assign mac_exp  = 2'(MAC_WIRE >> {cnt_q[4:0], 1'b0});
  assign type_exp = 2'(TYPE_WIRE >> {cnt_q[2:0], 1'b0});

  // Input sampling; in_vld marks that crsdv_q holds a real sample, not its reset value.
  always_comb begin
    crsdv_d  = crsdv;
    rxd_d    = rxd;
    in_vld_d = 1'b1;
  end

  // Next-state, header filtering, delay line and output pulses.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    uc_ok_d      = uc_ok_q;
    bc_ok_d      = bc_ok_q;
    type_ok_d    = type_ok_q;
    line_d       = line_q;
    occ_d        = occ_q;
    pay_cnt_d    = pay_cnt_q;
    axiov_d      = 1'b0;
    axiod_d      = 2'b00;
    frame_done_d = 1'b0;
    crc_ok_d     = 1'b0;
    frame_err_d  = 1'b0;
    crc_clear    = 1'b0;
    crc_en       = 1'b0;
    // A frame may only start after carrier has been seen low, so a frame
    // already in flight when reset released is never picked up mid-way.
    armed_d      = armed_q | (in_vld_q & ~crsdv_q);

    unique case (state_q)
      S_IDLE: begin
        if (armed_q && crsdv_q && rxd_q == 2'b01) begin
          state_d = S_PREAMBLE;
          cnt_d   = 8'd1;
          armed_d = 1'b0;
        end
      end

      S_PREAMBLE: begin
        if (!crsdv_q) begin
          state_d = S_IDLE;
        end else if (rxd_q == 2'b01) begin
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        end else if (rxd_q == 2'b11 && cnt_q >= PREAMBLE_MIN) begin
          state_d   = S_DST;
          cnt_d     = 8'd0;
          uc_ok_d   = 1'b1;
          bc_ok_d   = 1'b1;
          type_ok_d = 1'b1;
          crc_clear = 1'b1;
        end else begin
          state_d = S_DROP;
        end
      end

      S_DST: begin
        if (!crsdv_q) begin
          state_d     = S_IDLE;
          frame_err_d = 1'b1;
        end else begin
          crc_en  = 1'b1;
          uc_ok_d = uc_ok_q & (rxd_q == mac_exp);
          bc_ok_d = bc_ok_q & (rxd_q == 2'b11);
          if (cnt_q == DST_DIBITS - 8'd1) begin
            cnt_d   = 8'd0;
            state_d = (uc_ok_d || bc_ok_d) ? S_SRC : S_DROP;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end

      S_SRC: begin
        if (!crsdv_q) begin
          state_d     = S_IDLE;
          frame_err_d = 1'b1;
        end else begin
          crc_en = 1'b1;
          if (cnt_q == SRC_DIBITS - 8'd1) begin
            cnt_d   = 8'd0;
            state_d = S_TYPE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end

      S_TYPE: begin
        if (!crsdv_q) begin
          state_d     = S_IDLE;
          frame_err_d = 1'b1;
        end else begin
          crc_en    = 1'b1;
          type_ok_d = type_ok_q & (rxd_q == type_exp);
          if (cnt_q == TYPE_DIBITS - 8'd1) begin
            cnt_d     = 8'd0;
            occ_d     = 5'd0;
            pay_cnt_d = 16'd0;
            state_d   = type_ok_d ? S_PAYLOAD : S_DROP;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end

      S_PAYLOAD: begin
        if (!crsdv_q) begin
          state_d = S_IDLE;
          if (pay_cnt_q[1:0] == 2'b00 && pay_cnt_q >= MIN_PAYLOAD_DIBITS) begin
            frame_done_d = 1'b1;
            crc_ok_d     = (crc == CRC_RESIDUE);
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          crc_en = 1'b1;
          line_d = {line_q[29:0], rxd_q};
          // The newest 16 dibits are held back; they become the FCS at frame end.
          if (occ_q == FCS_DIBITS) begin
            axiov_d = 1'b1;
            axiod_d = line_q[31:30];
          end else begin
            occ_d = occ_q + 5'd1;
          end
          if (pay_cnt_q != 16'hFFFF) pay_cnt_d = pay_cnt_q + 16'd1;
        end
      end

      S_DROP: begin
        if (!crsdv_q) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      crsdv_q      <= 1'b0;
      rxd_q        <= 2'b00;
      in_vld_q     <= 1'b0;
      state_q      <= S_IDLE;
      cnt_q        <= 8'd0;
      armed_q      <= 1'b0;
      uc_ok_q      <= 1'b0;
      bc_ok_q      <= 1'b0;
      type_ok_q    <= 1'b0;
      line_q       <= 32'd0;
      occ_q        <= 5'd0;
      pay_cnt_q    <= 16'd0;
      axiov_q      <= 1'b0;
      axiod_q      <= 2'b00;
      frame_done_q <= 1'b0;
      crc_ok_q     <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      crsdv_q      <= crsdv_d;
      rxd_q        <= rxd_d;
      in_vld_q     <= in_vld_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      armed_q      <= armed_d;
      uc_ok_q      <= uc_ok_d;
      bc_ok_q      <= bc_ok_d;
      type_ok_q    <= type_ok_d;
      line_q       <= line_d;
      occ_q        <= occ_d;
      pay_cnt_q    <= pay_cnt_d;
      axiov_q      <= axiov_d;
      axiod_q      <= axiod_d;
      frame_done_q <= frame_done_d;
      crc_ok_q     <= crc_ok_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign axiov      = axiov_q;
  assign axiod      = axiod_q;
  assign frame_done = frame_done_q;
  assign crc_ok     = crc_ok_q;
  assign frame_err  = frame_err_q;

endmodule
